uart_reg_bridge: RTL
====================

# uart_reg_bridge

Byte-stream to register-bus bridge placed directly downstream of the UART escape controller. It consumes the controller's data stream (`rx_*`) and command stream (`cmd_*`), parses fixed-format read/write frames, and issues single 32-bit transactions on a simple register bus. It returns status and read data as bytes on the controller's transmit stream (`tx_*`). Escaped commands resynchronise the frame parser.

## Interface
- `OP_READ`, 8'h01, opcode for a register read
- `OP_WRITE`, 8'h02, opcode for a register write
- `CMD_SYNC`, 8'h00, command byte that aborts any frame in progress
- `TIMEOUT`, 1000, cycles to wait for `bus_ack` after a strobe (1..65535)

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rx_data`  in  8  data byte from controller
- `rx_valid`  in  1  data byte available
- `rx_ready`  out  1  bridge accepts data byte this cycle
- `cmd_data`  in  8  command byte from controller
- `cmd_valid`  in  1  command byte available
- `cmd_ready`  out  1  tied 1; commands always consumed
- `tx_data`  out  8  response byte to controller
- `tx_valid`  out  1  response byte offered
- `tx_ready`  in  1  controller transmitter idle
- `bus_addr`  out  8  register address
- `bus_wdata`  out  32  write data
- `bus_we`  out  1  one-cycle write strobe
- `bus_re`  out  1  one-cycle read strobe
- `bus_rdata`  in  32  read data, valid with `bus_ack`
- `bus_ack`  in  1  transaction complete

## Operation
- Frames: `[op][addr]` for a read; `[op][addr][d0][d1][d2][d3]` for a write. Data is little-endian, so d0 = wdata[7:0].
- Responses:
  - Write: one status byte.
  - Read: status byte, then 4 data bytes little-endian if status = 0x00.
  - Status codes: 0x00 ok, 0x01 bus timeout, 0x02 unknown opcode.
- States:
  - IDLE: `rx_ready`=1. Accepting op = OP_READ/OP_WRITE → ADDR. Any other op → RESP with status 0x02; no bus access.
  - ADDR: `rx_ready`=1. On accept, latch `bus_addr`. Read → BUS; write → WDATA with byte count 0.
  - WDATA: `rx_ready`=1. Each accept fills byte[count] of `bus_wdata`. The accept at count = 3 → BUS.
  - BUS:
    - First cycle: drive `bus_we` or `bus_re` for exactly one cycle and clear the 16-bit timeout counter.
    - `bus_ack` (allowed in the strobe cycle itself): latch `bus_rdata` for reads, status 0x00 → RESP.
    - Counter reaching TIMEOUT without ack: status 0x01 → RESP.
    - `bus_ack` outside BUS is ignored.
  - RESP: send status byte. Then → RDATA (read with status 0x00, byte index 0) or IDLE.
  - RDATA: send byte[index]; after index 3 → IDLE.
- `rx_ready` = 0 in BUS, RESP and RDATA, back-pressuring the controller.
- Tx handshake:
  - A byte transfers in a cycle with `tx_valid` && `tx_ready`.
  - Next cycle `tx_valid` = 0 for at least one cycle (covers transmitter busy latency).
  - The next byte is offered only when `tx_ready` = 1.
  - `tx_data` is stable while `tx_valid` = 1.
- Commands:
  - A `cmd_valid` with `cmd_data` == CMD_SYNC in any state forces IDLE next cycle.
  - The abort drops `tx_valid` and any pending response, abandons a pending bus wait, and generates no strobe.
  - Other command values are consumed and ignored.
  - If an abort coincides with an rx accept or tx transfer, the abort wins. The byte is treated as consumed/sent and discarded.

## Timing
- Reset values: `rx_ready`=1 (IDLE), `cmd_ready`=1, `tx_valid`=0, `tx_data`=0, `bus_we`=0, `bus_re`=0, `bus_addr`=0, `bus_wdata`=0; state IDLE, all counters 0.
- Reset is asynchronous; asserting it mid-frame or mid-response returns to IDLE immediately.
- Strobe timing: the strobe asserts in the cycle after the final frame byte is accepted (the addr byte for a read, d3 for a write).
- Response timing: `tx_valid` asserts in the cycle after `bus_ack`, provided `tx_ready` = 1. An unknown opcode's status is offered in the cycle after the op byte is accepted.
- Timeout: declared in the cycle when the counter equals TIMEOUT, i.e. TIMEOUT cycles after the strobe. A `bus_ack` in that same cycle takes priority (status 0x00).
- `bus_addr` and `bus_wdata` hold their values until the next frame overwrites them.

## Test plan
- Write: rx 02 10 78 56 34 12 → one `bus_we` pulse with addr 0x10, wdata 0x12345678. Ack 3 cycles later → tx 00.
- Read: rx 01 20; `bus_rdata` = 0xDEADBEEF with ack in the strobe cycle → tx 00 EF BE AD DE, each byte with its own handshake.
- Timeout: TIMEOUT=8, read, no ack → tx 01 after 8 cycles. A late `bus_ack` afterwards → no extra tx and no state change.
- Unknown op: rx 7F → tx 02, no strobe. Next frame 01 05 parses normally.
- Abort: rx 02 10 AA, then `cmd_valid` with 00 → IDLE, no strobe, no tx. Fresh write frame completes correctly; a cmd byte 0x42 mid-frame is ignored.
- Back-pressure: hold `tx_ready`=0 for 50 cycles during a read response → `tx_valid` held, `tx_data` stable, `rx_ready`=0 throughout. Bytes are delivered in order once released. Async `rst` asserted mid-RDATA → all outputs at reset values.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// Parses [op][addr]([d0..d3]) byte frames into single register-bus accesses and returns status/read bytes.
// A CMD_SYNC command byte aborts any frame, bus wait or response and returns the parser to IDLE.
module uart_reg_bridge #(
    parameter int         TIMEOUT  = 1000,
    parameter logic [7:0] OP_READ  = 8'h01,
    parameter logic [7:0] OP_WRITE = 8'h02,
    parameter logic [7:0] CMD_SYNC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP, S_RDATA} state_t;

    localparam logic [15:0] TO_CYC = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic        is_read_q, is_read_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        sync, rx_acc, strobe;

    assign sync      = cmd_valid && (cmd_data == CMD_SYNC);
    assign cmd_ready = 1'b1;
    assign rx_ready  = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign rx_acc    = rx_valid && rx_ready;
    // The first BUS cycle is the only one with a zero counter; an abort there suppresses the strobe.
    assign strobe    = (state_q == S_BUS) && (cnt_q == 16'd0) && !sync;
    assign bus_we    = strobe && !is_read_q;
    assign bus_re    = strobe && is_read_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (rx_acc) begin
                    if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                        is_read_d = (rx_data == OP_READ);
                        state_d   = S_ADDR;
                    end else begin
                        status_d   = 8'h02;
                        state_d    = S_RESP;
                        tx_valid_d = tx_ready;
                        tx_data_d  = 8'h02;
                    end
                end
            end
            S_ADDR: begin
                if (rx_acc) begin
                    bus_addr_d = rx_data;
                    cnt_d      = 16'd0;
                    idx_d      = 2'd0;
                    state_d    = is_read_q ? S_BUS : S_WDATA;
                end
            end
            S_WDATA: begin
                if (rx_acc) begin
                    bus_wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d   = 16'd0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_ack) begin
                    if (is_read_q) rdata_d = bus_rdata;
                    status_d   = 8'h00;
                    state_d    = S_RESP;
                    tx_valid_d = tx_ready;
                    tx_data_d  = 8'h00;
                end else if (cnt_q == TO_CYC) begin
                    status_d   = 8'h01;
                    state_d    = S_RESP;
                    tx_valid_d = tx_ready;
                    tx_data_d  = 8'h01;
                end
            end
            S_RESP: begin
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        idx_d      = 2'd0;
                        state_d    = (is_read_q && status_q == 8'h00) ? S_RDATA : S_IDLE;
                    end
                end else if (tx_ready) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = status_q;
                end
            end
            S_RDATA: begin
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        idx_d      = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = S_IDLE;
                    end
                end else if (tx_ready) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = rdata_q[{idx_q, 3'b000} +: 8];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any simultaneous accept or transfer: that byte is dropped.
        if (sync) begin
            state_d     = S_IDLE;
            idx_d       = 2'd0;
            cnt_d       = 16'd0;
            tx_valid_d  = 1'b0;
            bus_addr_d  = bus_addr_q;
            bus_wdata_d = bus_wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_read_q   <= 1'b0;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            status_q    <= 8'h00;
            rdata_q     <= 32'h0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            bus_addr_q  <= 8'h00;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end
endmodule
